// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: hardwired control sequencer for the register-transfer datapath.
// Steps one instruction through fetch (T0-T2) and execute (T3-T6) and drives
// the datapath's one-hot control strobes. Outputs are Moore-style: a function
// of the current state and the ir fields fed back from the datapath.
//
// Ports:
//   clk, reset          system clock; synchronous active-high reset
//   start               begin one instruction (sampled only in IDLE)
//   ir[31:0]            instruction register contents from the datapath
//   busy, done, illegal sequencer status
//   r_in[15:0]          one-hot register write enables R0..R15
//   r_out[15:0]         one-hot register bus drives R0..R15
//   pc_out .. lo_in     single-bit datapath strobes
//   alu_op[12:0]        one-hot ALU select
//                       [0]AND [1]OR [2]ADD [3]SUB [4]MUL [5]DIV [6]SHR
//                       [7]SHRA [8]SHL [9]ROR [10]ROL [11]NEG [12]NOT
module alu_seq_ctrl #(
    parameter bit AUTO_RUN = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] ir,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [15:0] r_in,
    output logic [15:0] r_out,
    output logic        pc_out,
    output logic        pc_in,
    output logic        inc_pc,
    output logic        mar_in,
    output logic        read,
    output logic        mdr_in,
    output logic        mdr_out,
    output logic        ir_in,
    output logic        y_in,
    output logic        z_in,
    output logic        zlow_out,
    output logic        zhigh_out,
    output logic        hi_in,
    output logic        lo_in,
    output logic [12:0] alu_op
);

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, FAULT
    } state_t;

    // Instruction class: A = Ra <- Rb op Rc, M = HI:LO <- Ra op Rb,
    // U = Ra <- op Rb, X = undefined opcode.
    typedef enum logic [1:0] {
        CLS_A, CLS_M, CLS_U, CLS_X
    } cls_t;

    localparam int ALU_AND  = 0;
    localparam int ALU_OR   = 1;
    localparam int ALU_ADD  = 2;
    localparam int ALU_SUB  = 3;
    localparam int ALU_MUL  = 4;
    localparam int ALU_DIV  = 5;
    localparam int ALU_SHR  = 6;
    localparam int ALU_SHRA = 7;
    localparam int ALU_SHL  = 8;
    localparam int ALU_ROR  = 9;
    localparam int ALU_ROL  = 10;
    localparam int ALU_NEG  = 11;
    localparam int ALU_NOT  = 12;

    state_t      state, state_nx, end_state;
    cls_t        cls;
    logic [12:0] alu_sel;
    logic [4:0]  opcode;
    logic [15:0] ra_oh, rb_oh, rc_oh;
    logic        unused_ir;

    assign opcode    = ir[31:27];
    assign ra_oh     = 16'h0001 << ir[26:23];
    assign rb_oh     = 16'h0001 << ir[22:19];
    assign rc_oh     = 16'h0001 << ir[18:15];
    assign unused_ir = ^ir[14:0];

    // Where a completed instruction goes next.
    assign end_state = AUTO_RUN ? T0 : IDLE;

    always_comb begin
        cls     = CLS_X;
        alu_sel = '0;
        case (opcode)
            5'b00011: begin cls = CLS_A; alu_sel[ALU_ADD]  = 1'b1; end
            5'b00100: begin cls = CLS_A; alu_sel[ALU_SUB]  = 1'b1; end
            5'b00101: begin cls = CLS_A; alu_sel[ALU_AND]  = 1'b1; end
            5'b00110: begin cls = CLS_A; alu_sel[ALU_OR]   = 1'b1; end
            5'b00111: begin cls = CLS_A; alu_sel[ALU_ROR]  = 1'b1; end
            5'b01000: begin cls = CLS_A; alu_sel[ALU_ROL]  = 1'b1; end
            5'b01001: begin cls = CLS_A; alu_sel[ALU_SHR]  = 1'b1; end
            5'b01010: begin cls = CLS_A; alu_sel[ALU_SHRA] = 1'b1; end
            5'b01011: begin cls = CLS_A; alu_sel[ALU_SHL]  = 1'b1; end
            5'b01110: begin cls = CLS_M; alu_sel[ALU_MUL]  = 1'b1; end
            5'b01111: begin cls = CLS_M; alu_sel[ALU_DIV]  = 1'b1; end
            5'b10000: begin cls = CLS_U; alu_sel[ALU_NEG]  = 1'b1; end
            5'b10001: begin cls = CLS_U; alu_sel[ALU_NOT]  = 1'b1; end
            default:  begin cls = CLS_X; alu_sel = '0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        illegal   = 1'b0;
        r_in      = '0;
        r_out     = '0;
        pc_out    = 1'b0;
        pc_in     = 1'b0;
        inc_pc    = 1'b0;
        mar_in    = 1'b0;
        read      = 1'b0;
        mdr_in    = 1'b0;
        mdr_out   = 1'b0;
        ir_in     = 1'b0;
        y_in      = 1'b0;
        z_in      = 1'b0;
        zlow_out  = 1'b0;
        zhigh_out = 1'b0;
        hi_in     = 1'b0;
        lo_in     = 1'b0;
        alu_op    = '0;

        case (state)
            IDLE: if (start) state_nx = T0;
            T0: begin
                pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; pc_in = 1'b1;
                state_nx = T1;
            end
            T1: begin
                read = 1'b1; mdr_in = 1'b1;
                state_nx = T2;
            end
            T2: begin
                mdr_out = 1'b1; ir_in = 1'b1;
                state_nx = T3;
            end
            T3: begin
                state_nx = T4;
                case (cls)
                    CLS_A: begin r_out = rb_oh; y_in = 1'b1; end
                    CLS_M: begin r_out = ra_oh; y_in = 1'b1; end
                    CLS_U: begin r_out = rb_oh; alu_op = alu_sel; z_in = 1'b1; end
                    default: state_nx = FAULT;
                endcase
            end
            T4: begin
                state_nx = T5;
                case (cls)
                    CLS_A: begin r_out = rc_oh; alu_op = alu_sel; z_in = 1'b1; end
                    CLS_M: begin r_out = rb_oh; alu_op = alu_sel; z_in = 1'b1; end
                    CLS_U: begin
                        zlow_out = 1'b1; r_in = ra_oh; done = 1'b1;
                        state_nx = end_state;
                    end
                    // ir changed under us mid-instruction; abandon it.
                    default: state_nx = IDLE;
                endcase
            end
            T5: begin
                case (cls)
                    CLS_A: begin
                        zlow_out = 1'b1; r_in = ra_oh; done = 1'b1;
                        state_nx = end_state;
                    end
                    CLS_M: begin
                        zlow_out = 1'b1; lo_in = 1'b1;
                        state_nx = T6;
                    end
                    default: state_nx = IDLE;
                endcase
            end
            T6: begin
                zhigh_out = 1'b1; hi_in = 1'b1; done = 1'b1;
                state_nx = end_state;
            end
            FAULT: begin
                illegal  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: two instances (AUTO_RUN=0 and AUTO_RUN=1) with
// independent inputs. A behavioural model tracks the step number inside the
// current instruction and derives every output from the strobe tables.
module tb_alu_seq_ctrl;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        illegal;
        logic [15:0] r_in;
        logic [15:0] r_out;
        logic [13:0] strb;
        logic [12:0] alu_op;
    } obs_t;

    localparam int PC_OUT = 13, PC_IN = 12, INC_PC = 11, MAR_IN = 10;
    localparam int READ = 9, MDR_IN = 8, MDR_OUT = 7, IR_IN = 6, Y_IN = 5;
    localparam int Z_IN = 4, ZLOW = 3, ZHIGH = 2, HI_IN = 1, LO_IN = 0;

    logic        clk = 1'b0;
    logic        reset_v [2];
    logic        start_v [2];
    logic [31:0] ir_v    [2];
    obs_t        obs_w   [2];
    int          ph      [2];   // -1 = idle, else step index from T0
    int          errors = 0;
    int          checks = 0;
    bit          chk_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic        busy, done, illegal;
        logic [15:0] r_in, r_out;
        logic [12:0] alu_op;
        logic        pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out;
        logic        ir_in, y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in;

        alu_seq_ctrl #(.AUTO_RUN(g == 1)) dut (
            .clk(clk), .reset(reset_v[g]), .start(start_v[g]), .ir(ir_v[g]),
            .busy(busy), .done(done), .illegal(illegal),
            .r_in(r_in), .r_out(r_out),
            .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in),
            .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
            .y_in(y_in), .z_in(z_in), .zlow_out(zlow_out),
            .zhigh_out(zhigh_out), .hi_in(hi_in), .lo_in(lo_in),
            .alu_op(alu_op)
        );

        assign obs_w[g] = {busy, done, illegal, r_in, r_out,
                           pc_out, pc_in, inc_pc, mar_in, read, mdr_in,
                           mdr_out, ir_in, y_in, z_in, zlow_out, zhigh_out,
                           hi_in, lo_in, alu_op};
    end

    // ---------------- behavioural model ----------------
    // class: 0 = A (Ra<-Rb op Rc), 1 = M (HI:LO<-Ra op Rb), 2 = U, 3 = illegal
    function automatic int cls_of(input logic [4:0] op);
        if (op >= 5'd3 && op <= 5'd11) return 0;
        if (op == 5'd14 || op == 5'd15) return 1;
        if (op == 5'd16 || op == 5'd17) return 2;
        return 3;
    endfunction

    function automatic int alu_bit(input logic [4:0] op);
        case (op)
            5'd3:  return 2;  5'd4:  return 3;  5'd5:  return 0;
            5'd6:  return 1;  5'd7:  return 9;  5'd8:  return 10;
            5'd9:  return 6;  5'd10: return 7;  5'd11: return 8;
            5'd14: return 4;  5'd15: return 5;  5'd16: return 11;
            5'd17: return 12;
            default: return -1;
        endcase
    endfunction

    // Cycles from T0 through the done (or FAULT) cycle.
    function automatic int inst_len(input logic [31:0] ir);
        case (cls_of(ir[31:27]))
            0: return 6;
            1: return 7;
            2: return 5;
            default: return 5;
        endcase
    endfunction

    function automatic obs_t model_obs(input int k, input logic [31:0] ir);
        obs_t        o;
        int          c, s;
        logic [15:0] ra, rb, rc;
        logic [12:0] alu;
        o  = '0;
        ra = 16'd1 << ir[26:23];
        rb = 16'd1 << ir[22:19];
        rc = 16'd1 << ir[18:15];
        c  = cls_of(ir[31:27]);
        alu = '0;
        if (c != 3) alu[alu_bit(ir[31:27])] = 1'b1;
        o.busy = 1'b1;
        s = k - 3;
        if (k == 0) begin
            o.strb[PC_OUT] = 1; o.strb[MAR_IN] = 1;
            o.strb[INC_PC] = 1; o.strb[PC_IN] = 1;
        end else if (k == 1) begin
            o.strb[READ] = 1; o.strb[MDR_IN] = 1;
        end else if (k == 2) begin
            o.strb[MDR_OUT] = 1; o.strb[IR_IN] = 1;
        end else if (c == 0) begin
            if (s == 0) begin o.r_out = rb; o.strb[Y_IN] = 1; end
            if (s == 1) begin o.r_out = rc; o.alu_op = alu; o.strb[Z_IN] = 1; end
            if (s == 2) begin o.strb[ZLOW] = 1; o.r_in = ra; o.done = 1; end
        end else if (c == 1) begin
            if (s == 0) begin o.r_out = ra; o.strb[Y_IN] = 1; end
            if (s == 1) begin o.r_out = rb; o.alu_op = alu; o.strb[Z_IN] = 1; end
            if (s == 2) begin o.strb[ZLOW] = 1; o.strb[LO_IN] = 1; end
            if (s == 3) begin o.strb[ZHIGH] = 1; o.strb[HI_IN] = 1; o.done = 1; end
        end else if (c == 2) begin
            if (s == 0) begin o.r_out = rb; o.alu_op = alu; o.strb[Z_IN] = 1; end
            if (s == 1) begin o.strb[ZLOW] = 1; o.r_in = ra; o.done = 1; end
        end else begin
            if (s == 1) o.illegal = 1;
        end
        return o;
    endfunction

    initial begin
        ph[0] = -1;
        ph[1] = -1;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset_v[i])
                ph[i] <= -1;
            else if (ph[i] < 0)
                ph[i] <= start_v[i] ? 0 : -1;
            else if (ph[i] == inst_len(ir_v[i]) - 1)
                ph[i] <= (i == 1 && cls_of(ir_v[i][31:27]) != 3) ? 0 : -1;
            else
                ph[i] <= ph[i] + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                obs_t e;
                e = (ph[i] < 0) ? obs_t'('0) : model_obs(ph[i], ir_v[i]);
                chk($sformatf("model_dut%0d", i), 64'(obs_w[i]), 64'(e));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int i, input logic [31:0] ir);
        ir_v[i]    = ir;
        start_v[i] = 1'b1;
        step();
        start_v[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, output int n);
        n = 1;
        while (obs_w[i].done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
    endtask

    function automatic logic [31:0] rand_ir();
        logic [4:0]  tbl [13];
        logic [31:0] r;
        tbl = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                5'd14, 5'd15, 5'd16, 5'd17};
        r = $urandom;
        if ($urandom_range(0, 5) != 0)
            r[31:27] = tbl[$urandom_range(0, 12)];
        return r;
    endfunction

    int n;

    initial begin
        for (int i = 0; i < 2; i++) begin
            reset_v[i] = 1'b1;
            start_v[i] = 1'b0;
            ir_v[i]    = '0;
        end
        step();
        step();
        chk_en = 1'b1;
        reset_v[0] = 1'b0;
        reset_v[1] = 1'b0;
        chk("reset_obs0", 64'(obs_w[0]), 64'd0);
        chk("reset_obs1", 64'(obs_w[1]), 64'd0);

        // DIV R2,R6
        launch(0, 32'h7930_0000);
        chk("div_t0_pc_out", 64'(obs_w[0].strb[PC_OUT]), 64'd1);
        step(); step(); step();
        chk("div_t3_r_out", 64'(obs_w[0].r_out), 64'h0004);
        chk("div_t3_y_in", 64'(obs_w[0].strb[Y_IN]), 64'd1);
        step();
        chk("div_t4_r_out", 64'(obs_w[0].r_out), 64'h0040);
        chk("div_t4_alu", 64'(obs_w[0].alu_op), 64'h0020);
        chk("div_t4_z_in", 64'(obs_w[0].strb[Z_IN]), 64'd1);
        step();
        chk("div_t5_lo", 64'({obs_w[0].strb[ZLOW], obs_w[0].strb[LO_IN], obs_w[0].done}), 64'b110);
        step();
        chk("div_t6_hi", 64'({obs_w[0].strb[ZHIGH], obs_w[0].strb[HI_IN], obs_w[0].done}), 64'b111);
        step();
        chk("div_after_busy", 64'(obs_w[0].busy), 64'd0);

        // ADD R5,R2,R4
        launch(0, 32'h1A92_0000);
        step(); step(); step();
        chk("add_t3_r_out", 64'(obs_w[0].r_out), 64'h0004);
        step();
        chk("add_t4_r_out", 64'(obs_w[0].r_out), 64'h0010);
        chk("add_t4_alu", 64'(obs_w[0].alu_op), 64'h0004);
        step();
        chk("add_t5_r_in", 64'(obs_w[0].r_in), 64'h0020);
        chk("add_t5_done", 64'(obs_w[0].done), 64'd1);
        step();

        // NEG R7,R3
        launch(0, 32'h8398_0000);
        step(); step(); step();
        chk("neg_t3_r_out", 64'(obs_w[0].r_out), 64'h0008);
        chk("neg_t3_alu", 64'(obs_w[0].alu_op), 64'h0800);
        step();
        chk("neg_t4_r_in", 64'(obs_w[0].r_in), 64'h0080);
        chk("neg_t4_done", 64'(obs_w[0].done), 64'd1);
        step();

        // latencies
        launch(0, {5'b01110, 27'($urandom)});
        wait_done(0, n);
        chk("mul_latency", 64'(n), 64'd7);
        step();
        launch(0, {5'b00110, 27'($urandom)});
        wait_done(0, n);
        chk("or_latency", 64'(n), 64'd6);
        step();
        launch(0, {5'b10001, 27'($urandom)});
        wait_done(0, n);
        chk("not_latency", 64'(n), 64'd5);
        step();

        // illegal opcode on the AUTO_RUN instance
        launch(1, 32'hF800_0000);
        step(); step(); step();
        chk("ill_t3_quiet", 64'({obs_w[1].r_out, obs_w[1].strb, obs_w[1].alu_op}), 64'd0);
        step();
        chk("ill_fault", 64'(obs_w[1]), 64'(obs_t'({3'b101, 59'd0})));
        step();
        chk("ill_then_idle", 64'(obs_w[1]), 64'd0);

        // reset during T4 of ADD, with an ignored start while busy
        launch(0, 32'h1A92_0000);
        step();
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        step(); step();
        chk("rst_t4_busy", 64'(obs_w[0].busy), 64'd1);
        reset_v[0] = 1'b1;
        start_v[0] = 1'b1;
        step();
        reset_v[0] = 1'b0;
        start_v[0] = 1'b0;
        chk("rst_mid_obs", 64'(obs_w[0]), 64'd0);
        step();
        chk("rst_no_queue", 64'(obs_w[0].busy), 64'd0);

        // AUTO_RUN: back-to-back ADDs, busy never drops
        launch(1, 32'h1A92_0000);
        wait_done(1, n);
        chk("auto_lat1", 64'(n), 64'd6);
        step();
        chk("auto_t0", 64'({obs_w[1].busy, obs_w[1].strb[PC_OUT],
                            obs_w[1].strb[INC_PC], obs_w[1].strb[PC_IN]}), 64'hF);
        wait_done(1, n);
        chk("auto_lat2", 64'(n), 64'd6);
        reset_v[1] = 1'b1;
        step();
        reset_v[1] = 1'b0;

        // randomized traffic on both instances
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 2; i++) begin
                reset_v[i] = ($urandom_range(0, 63) == 0);
                start_v[i] = ($urandom_range(0, 2) == 0);
                if (ph[i] <= 2 && $urandom_range(0, 1) == 1)
                    ir_v[i] = rand_ir();
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Hardwired control sequencer for the register-transfer datapath. It drives the one-hot control strobes the datapath consumes, stepping through one instruction's fetch (T0–T2) and execute (T3–T6) phases for register-register ALU, multiply/divide and unary instructions. It decodes the instruction register contents fed back from the datapath. It sits between the top-level CPU and the datapath, replacing the hand-sequenced strobes currently driven from benches.

## Interface
- AUTO_RUN, 0, when 1, a completed instruction proceeds directly to T0 of the next fetch instead of IDLE.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin one instruction; sampled only in IDLE.
- ir  in  32  current IR contents from the datapath.
  - opcode = ir[31:27], Ra = ir[26:23], Rb = ir[22:19], Rc = ir[18:15].
- busy  out  1  high in every T state and in FAULT.
- done  out  1  high for exactly the final execute cycle of an instruction.
- illegal  out  1  high for one cycle in FAULT.
- r_in  out  16  one-hot register write enables, R0..R15.
- r_out  out  16  one-hot register bus drives, R0..R15.
- pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in, y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in  out  1 each  datapath strobes.
- alu_op  out  13  one-hot ALU select.
  - Bit order: [0]AND [1]OR [2]ADD [3]SUB [4]MUL [5]DIV [6]SHR [7]SHRA [8]SHL [9]ROR [10]ROL [11]NEG [12]NOT.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, FAULT. Each state lasts one cycle.
- Outputs are combinational from the state and the ir fields (Moore style). Every strobe not listed for a state is 0.
- IDLE: all strobes 0. start=1 → T0; otherwise stay in IDLE.
- Fetch:
  - T0: pc_out, mar_in, inc_pc, pc_in.
  - T1: read, mdr_in.
  - T2: mdr_out, ir_in.
- Opcode table:
  - 00011 ADD, 00100 SUB, 00101 AND, 00110 OR, 00111 ROR, 01000 ROL, 01001 SHR, 01010 SHRA, 01011 SHL (class A).
  - 01110 MUL, 01111 DIV (class M).
  - 10000 NEG, 10001 NOT (class U).
  - Any other opcode: T3 → FAULT. No strobes assert in that T3.
- Class A (Ra ← Rb op Rc):
  - T3: r_out[Rb], y_in.
  - T4: r_out[Rc], alu_op, z_in.
  - T5: zlow_out, r_in[Ra], done.
- Class M (HI:LO ← Ra op Rb):
  - T3: r_out[Ra], y_in.
  - T4: r_out[Rb], alu_op, z_in.
  - T5: zlow_out, lo_in.
  - T6: zhigh_out, hi_in, done.
- Class U (Ra ← op Rb):
  - T3: r_out[Rb], alu_op, z_in.
  - T4: zlow_out, r_in[Ra], done.
- alu_op asserts only in the cycle that has z_in.
- Exactly one of r_out bits is high when any is high; the same holds for r_in. R0 is writable like any other register.
- After the done cycle: AUTO_RUN=0 → IDLE; AUTO_RUN=1 → T0.
- FAULT: illegal=1, busy=1, no datapath strobes. Next state is IDLE regardless of AUTO_RUN.

## Timing
- Reset, including mid-instruction: the next state is IDLE. Every output is 0 in the cycle after reset is sampled. Reset has priority over start.
- Latency from the start-sampled edge to the cycle with done high (T0 is the first cycle after the edge):
  - Class A: 6 cycles (T0..T5).
  - Class M: 7 cycles (T0..T6).
  - Class U: 5 cycles (T0..T4).
  - Illegal: 4 cycles (T0..T3) to FAULT, with illegal high in the 5th cycle.
- start while busy is ignored; it is not queued.
- start held high in IDLE with AUTO_RUN=0: the next instruction begins the cycle after the return to IDLE.
- ir is assumed stable from T3 through the done cycle. It is loaded on the T2 edge and no later state drives ir_in.
- Class M: Z captures the 64-bit result on the T4 edge. LO is written on the T5 edge and HI on the T6 edge.

## Test plan
- DIV R2,R6: ir=0x79300000.
  - T3: r_out=0x0004, y_in.
  - T4: r_out=0x0040, alu_op=0x0020, z_in.
  - T5: zlow_out, lo_in.
  - T6: zhigh_out, hi_in, done.
  - Then IDLE with busy=0.
- ADD R5,R2,R4: ir=0x1A920000.
  - T3: r_out=0x0004.
  - T4: r_out=0x0010, alu_op=0x0004.
  - T5: r_in=0x0020, done.
  - 6 cycles total.
- NEG R7,R3: ir=0x83980000.
  - T3: r_out=0x0008, alu_op=0x0800, z_in.
  - T4: zlow_out, r_in=0x0080, done.
- Illegal: ir=0xF8000000.
  - FAULT in the 5th cycle with illegal=1 and all strobes 0.
  - IDLE next, even with AUTO_RUN=1.
- Reset asserted during T4 of an ADD: the following cycle shows IDLE with every output 0. A start pulse during busy is also applied and has no effect.
- AUTO_RUN=1 with an ADD program: T5 is followed directly by T0 with pc_out, inc_pc and pc_in high; busy never drops.
